counter_161: RTL and testbench

- Emulation model of a 74xx161 synchronous presettable binary counter with asynchronous clear.
- Counter outputs q drive the a/b inputs of downstream logic-gate models, e.g. the 74xx02 bus-variant NOR, in the CPU emulator.
- Cycle-accurate and X-aware, matching the gate models: unknown control inputs must produce unknown state, never a silently "good" value.
- WIDTH parameter gives a bus variant. Cascading via rco/ent must behave like chained 4-bit 161s.

---
 rtl/counter_161_if.sv | 26 ++
 rtl/counter_161.sv | 59 +++++
 tb/tb_counter_161.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_161_if.sv
// Control, data and status bundle of one 74xx161 stage.
// Latency: not applicable (wires only).
// Backpressure: none; the counter accepts control every cycle.
//
// Signals: load_n/enp/ent/d are driven by the master (control logic or the
// previous cascade stage); q/rco come back from the counter (slave side).
interface counter_161_if #(
  parameter int WIDTH = 4
);
  logic             load_n;
  logic             enp;
  logic             ent;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rco;

  modport master (
    output load_n, enp, ent, d,
    input  q, rco
  );

  modport slave (
    input  load_n, enp, ent, d,
    output q, rco
  );
endinterface

// File: rtl/counter_161.sv
// 74xx161 presettable binary counter with asynchronous clear, X-aware.
// Latency: load/count visible 1 cycle after the rising edge; clear and rco combinational.
// Backpressure: none; enp/ent gate counting, load_n overrides them.
//
// Ports:
//   clk   - count clock, all synchronous actions on the rising edge
//   clr_n - asynchronous active-low clear (chip CLR pin)
//   bus   - slave side of counter_161_if: load_n, enp, ent, d in; q, rco out
module counter_161 #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  counter_161_if.slave  bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_out;

  // Next state: load beats count beats hold. The case-equality tests keep
  // an unknown control from being read as a definite 0 or 1, so an
  // unresolved control poisons the state instead of picking a branch.
  always_comb begin
    q_next = q_r;
    if (bus.load_n === 1'b0) begin
      q_next = bus.d;                 // per-bit copy, X bits stay X
    end else if (bus.load_n !== 1'b1) begin
      q_next = 'x;
    end else if (bus.enp === 1'b0 || bus.ent === 1'b0) begin
      q_next = q_r;                   // a known 0 on either enable holds
    end else if (bus.enp === 1'b1 && bus.ent === 1'b1) begin
      // Addition with any X operand bit yields all X.
      q_next = q_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      q_next = 'x;
    end
  end

  // A 1->X transition on clr_n is a negedge, so an unknown clear poisons the
  // state immediately; a later X->1 leaves it X until the next load.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_r <= '0;
    end else if (clr_n !== 1'b1) begin
      q_r <= 'x;
    end else begin
      q_r <= q_next;
    end
  end

  // An unknown clear must show on q right away even when the state was
  // already cleared (0->X is not a negedge).
  assign q_out = (clr_n === 1'b0 || clr_n === 1'b1) ? q_r : 'x;

  assign bus.q   = q_out;
  assign bus.rco = bus.ent & (&q_out);

endmodule

// File: tb/tb_counter_161.sv
module tb_counter_161;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_fail;
  bit   four_state;

  counter_161_if #(.WIDTH(4)) bus0 ();
  counter_161_if #(.WIDTH(4)) bus1 ();

  // Stage 1 counts only when stage 0 carries out.
  assign bus1.ent = bus0.rco;

  counter_161 #(.WIDTH(4)) u_stage0 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus0)
  );

  counter_161 #(.WIDTH(4)) u_stage1 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic probe;
    probe = 1'bx;
    four_state = $isunknown(probe);
    clr_n       = 1'b1;
    bus0.load_n = 1'b1;
    bus0.enp    = 1'b0;
    bus0.ent    = 1'b1;
    bus0.d      = 4'h0;
    bus1.load_n = 1'b1;
    bus1.enp    = 1'b0;
    bus1.d      = 4'h0;
    #1;
    if (four_state) begin
      n_checks++;
      if (bus0.q !== 4'bxxxx) begin
        n_fail++;
        $display("FAIL powerup_q: got %b want xxxx", bus0.q);
      end
    end
    clr_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.q !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_q: got %h want 0", bus0.q);
    end
    n_checks++;
    if (bus0.rco !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rco: got %b want 0", bus0.rco);
    end
  endtask

  task automatic test_async_clear();
    tick();
    clr_n       = 1'b1;              // released between edges
    bus0.load_n = 1'b0;
    bus0.d      = 4'h8;
    tick();
    bus0.load_n = 1'b1;
    bus0.enp    = 1'b1;
    bus0.ent    = 1'b1;
    tick();
    n_checks++;
    if (bus0.q !== 4'h9) begin
      n_fail++;
      $display("FAIL count_to_9: got %h want 9", bus0.q);
    end
    #2;
    clr_n = 1'b0;                    // mid-cycle, no edge
    #1;
    n_checks++;
    if (bus0.q !== 4'h0 || bus0.rco !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: got q=%h rco=%b want q=0 rco=0", bus0.q, bus0.rco);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus0.q !== 4'h0) begin
        n_fail++;
        $display("FAIL clear_hold_%0d: got %h want 0", i, bus0.q);
      end
    end
    #2;
    clr_n = 1'b1;
    #1;
    n_checks++;
    if (bus0.q !== 4'h0) begin
      n_fail++;
      $display("FAIL release_no_change: got %h want 0", bus0.q);
    end
    tick();
    n_checks++;
    if (bus0.q !== 4'h1) begin
      n_fail++;
      $display("FAIL first_count_after_release: got %h want 1", bus0.q);
    end
  endtask

  task automatic test_load_count();
    logic [3:0] exp_q   [3] = '{4'hE, 4'hF, 4'h0};
    logic       exp_rco [3] = '{1'b0, 1'b1, 1'b0};
    bus0.load_n = 1'b0;
    bus0.d      = 4'hD;
    tick();
    n_checks++;
    if (bus0.q !== 4'hD || bus0.rco !== 1'b0) begin
      n_fail++;
      $display("FAIL load_D: got q=%h rco=%b want q=d rco=0", bus0.q, bus0.rco);
    end
    bus0.load_n = 1'b1;
    bus0.enp    = 1'b1;
    bus0.ent    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus0.q !== exp_q[i] || bus0.rco !== exp_rco[i]) begin
        n_fail++;
        $display("FAIL count_step_%0d: got q=%h rco=%b want q=%h rco=%b",
                 i, bus0.q, bus0.rco, exp_q[i], exp_rco[i]);
      end
      if (i == 1) begin
        bus0.ent = 1'b0;
        #1;
        n_checks++;
        if (bus0.rco !== 1'b0) begin
          n_fail++;
          $display("FAIL rco_gated_by_ent: got %b want 0", bus0.rco);
        end
        bus0.ent = 1'b1;
      end
    end
  endtask

  task automatic test_enable();
    bus0.load_n = 1'b0;
    bus0.d      = 4'h5;
    tick();
    bus0.load_n = 1'b1;
    bus0.enp    = 1'b0;
    bus0.ent    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus0.q !== 4'h5) begin
        n_fail++;
        $display("FAIL hold_enp0_%0d: got %h want 5", i, bus0.q);
      end
    end
    bus0.enp = 1'b1;
    bus0.ent = 1'b0;
    tick();
    n_checks++;
    if (bus0.q !== 4'h5 || bus0.rco !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ent0: got q=%h rco=%b want q=5 rco=0", bus0.q, bus0.rco);
    end
    bus0.enp = 1'b0;
    bus0.ent = 1'bx;
    tick();
    n_checks++;
    if (bus0.q !== 4'h5) begin
      n_fail++;
      $display("FAIL hold_enp0_entx: got %h want 5", bus0.q);
    end
    bus0.ent = 1'b1;
  endtask

  // Only meaningful on a four-state simulator; a two-state one cannot hold X.
  task automatic test_x_prop();
    if (four_state) begin
      bus0.load_n = 1'b0;
      bus0.d      = 4'b1x01;
      tick();
      n_checks++;
      if (bus0.q !== 4'b1x01) begin
        n_fail++;
        $display("FAIL load_x_bits: got %b want 1x01", bus0.q);
      end
      bus0.load_n = 1'b1;
      bus0.enp    = 1'b1;
      bus0.ent    = 1'b1;
      tick();
      n_checks++;
      if (bus0.q !== 4'bxxxx) begin
        n_fail++;
        $display("FAIL count_from_x: got %b want xxxx", bus0.q);
      end
      bus0.load_n = 1'b0;
      bus0.d      = 4'h3;
      tick();
      bus0.load_n = 1'bx;
      tick();
      n_checks++;
      if (bus0.q !== 4'bxxxx) begin
        n_fail++;
        $display("FAIL load_n_x: got %b want xxxx", bus0.q);
      end
      bus0.load_n = 1'b0;
      tick();
      bus0.load_n = 1'b1;
      bus0.enp    = 1'bx;
      tick();
      n_checks++;
      if (bus0.q !== 4'bxxxx) begin
        n_fail++;
        $display("FAIL enp_x: got %b want xxxx", bus0.q);
      end
      bus0.enp    = 1'b0;
      bus0.load_n = 1'b0;
      bus0.d      = 4'b0xxx;
      tick();
      bus0.load_n = 1'b1;
      #1;
      n_checks++;
      if (bus0.rco !== 1'b0) begin
        n_fail++;
        $display("FAIL rco_known_zero_bit: got %b want 0", bus0.rco);
      end
      bus0.load_n = 1'b0;
      bus0.d      = 4'h6;
      tick();
      bus0.load_n = 1'b1;
      clr_n = 1'bx;
      #1;
      n_checks++;
      if (bus0.q !== 4'bxxxx) begin
        n_fail++;
        $display("FAIL clr_x: got %b want xxxx", bus0.q);
      end
      clr_n = 1'b1;
      #1;
      n_checks++;
      if (bus0.q !== 4'bxxxx) begin
        n_fail++;
        $display("FAIL clr_x_to_1: got %b want xxxx", bus0.q);
      end
      clr_n = 1'bx;
      #1;
      clr_n = 1'b0;
      #1;
      n_checks++;
      if (bus0.q !== 4'h0) begin
        n_fail++;
        $display("FAIL clr_x_to_0: got %b want 0000", bus0.q);
      end
      clr_n = 1'b1;
      bus0.enp = 1'b1;
    end
  endtask

  task automatic test_cascade();
    logic [3:0] prev1;
    int         incr;
    bus0.load_n = 1'b0;
    bus0.d      = 4'hF;
    bus1.load_n = 1'b0;
    bus1.d      = 4'h0;
    tick();
    bus0.load_n = 1'b1;
    bus1.load_n = 1'b1;
    bus0.enp    = 1'b1;
    bus0.ent    = 1'b1;
    bus1.enp    = 1'b1;
    tick();
    n_checks++;
    if ({bus1.q, bus0.q} !== 8'h10) begin
      n_fail++;
      $display("FAIL cascade_carry: got %h want 10", {bus1.q, bus0.q});
    end
    bus0.load_n = 1'b0;
    bus0.d      = 4'h0;
    bus1.load_n = 1'b0;
    bus1.d      = 4'h0;
    tick();
    bus0.load_n = 1'b1;
    bus1.load_n = 1'b1;
    incr = 0;
    for (int i = 0; i < 256; i++) begin
      prev1 = bus1.q;
      tick();
      if (bus1.q !== prev1) incr++;
      if (i == 16) begin
        n_checks++;
        if ({bus1.q, bus0.q} !== 8'h11) begin
          n_fail++;
          $display("FAIL cascade_mid: got %h want 11", {bus1.q, bus0.q});
        end
      end
    end
    n_checks++;
    if ({bus1.q, bus0.q} !== 8'h00) begin
      n_fail++;
      $display("FAIL cascade_wrap: got %h want 00", {bus1.q, bus0.q});
    end
    n_checks++;
    if (incr != 16) begin
      n_fail++;
      $display("FAIL cascade_stage1_steps: got %0d want 16", incr);
    end
    bus1.enp = 1'b0;
  endtask

  task automatic test_race();
    bus0.load_n = 1'b0;
    bus0.d      = 4'h7;
    tick();
    bus0.load_n = 1'b1;
    bus0.enp    = 1'b1;
    bus0.ent    = 1'b1;
    // Clear falls in the same timestep as the edge.
    @(posedge clk);
    clr_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.q !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_fall_race: got %h want 0", bus0.q);
    end
    tick();
    // Release lands in the same timestep as the edge; the flop must still
    // see clear asserted for that edge, like the chip's recovery window.
    @(posedge clk);
    clr_n <= 1'b1;
    #1;
    n_checks++;
    if (bus0.q !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_rise_race: got %h want 0", bus0.q);
    end
    tick();
    n_checks++;
    if (bus0.q !== 4'h1) begin
      n_fail++;
      $display("FAIL after_race_count: got %h want 1", bus0.q);
    end
  endtask

  task automatic test_back_to_back();
    // Load, count, load on consecutive edges.
    bus0.load_n = 1'b0;
    bus0.d      = 4'hA;
    tick();
    bus0.load_n = 1'b1;
    tick();
    n_checks++;
    if (bus0.q !== 4'hB) begin
      n_fail++;
      $display("FAIL b2b_count: got %h want b", bus0.q);
    end
    bus0.load_n = 1'b0;
    bus0.d      = 4'h2;
    tick();
    n_checks++;
    if (bus0.q !== 4'h2) begin
      n_fail++;
      $display("FAIL b2b_reload: got %h want 2", bus0.q);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_async_clear();
    test_load_count();
    test_enable();
    test_x_prop();
    test_cascade();
    test_race();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
